puzzle2_range_sched: RTL
========================

# puzzle2_range_sched

Range scheduler for the `puzzle2_1` invalid-ID summing core. It accepts ID range pairs from the input loader over a valid/ready stream and buffers them in a small FIFO. It issues one range at a time to the core with a single-cycle `wr_en` pulse, then waits for the core's `valid`. After the range flagged `last` completes, it captures the core's cumulative sum as the final answer and raises `done`.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `W`, 64: ID width.
- `WDOG`, 1048576: maximum cycles to wait for core `valid` before error.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `soft_clr` in 1: synchronous clear; same effect as reset.
- `in_valid` in 1: loader offers a range.
- `in_ready` out 1: scheduler accepts; transfer on `in_valid & in_ready` at a rising edge.
- `in_lo`, `in_hi` in W: range bounds, inclusive.
- `in_last` in 1: marks the final range of the puzzle input.
- `core_wr_en` out 1: one-cycle start pulse to the core.
- `core_id1`, `core_id2` out W: range presented to the core (id1 ≤ id2).
- `core_valid` in 1: core finished the current range.
- `core_sum` in W: core cumulative sum.
- `busy` out 1: a range is in flight (ISSUE or WAIT).
- `done` out 1: last range completed; sticky.
- `final_sum` out W: `core_sum` captured at completion of the last range.
- `range_cnt` out 16: number of ranges completed, wraps at 65535→0.
- `err` out 1: watchdog expired; sticky.

## Operation
- Reset / `soft_clr` value for every output and register is 0: FIFO empty, state IDLE, `last_seen` flag cleared.
- `in_ready = !full & !last_seen & !done & !err`. It reads 1 in the first cycle after reset release.
- Enqueue normalises each range: if `in_lo > in_hi`, the entry stores {`in_hi`, `in_lo`}. Equal bounds are legal. The `last` bit is stored with the entry. Accepting an entry with `in_last=1` sets `last_seen`.
- FIFO: circular buffer with DEPTH entries and a log2(DEPTH)+1-bit count.
  - Push when full is impossible, because `in_ready` is derived from the registered `full`. A same-cycle pop does not free the slot for that cycle's push.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty → ISSUE.
  - ISSUE, exactly one cycle: pop head; load `core_id1`/`core_id2` and the in-flight `last` bit; clear the watchdog counter → WAIT.
  - WAIT: the first WAIT cycle ignores `core_valid` (blanking for a stale level from the previous range). After that:
    - `core_valid=1` → increment `range_cnt`. If in-flight `last` is set, capture `final_sum <= core_sum` and go to DONE; otherwise go to IDLE.
    - If the watchdog counter reaches WDOG-1 with no `core_valid` → ERR.
  - DONE: `done=1`; absorbing state until reset or `soft_clr`. FIFO contents, if any, are discarded.
  - ERR: `err=1`; absorbing state; no further `core_wr_en` pulses.
- `core_wr_en` is registered: high for the one cycle following the ISSUE decision. `core_id1`/`core_id2` are stable from that cycle until the next ISSUE.
- `busy` is 1 in ISSUE and WAIT.
- The core shares `reset`. A reset mid-range aborts the range with no completion counted.
- `soft_clr` during WAIT abandons the in-flight range. The core itself is not cleared by `soft_clr`.

## Timing
- Handshake at edge k into an empty idle scheduler → `core_wr_en` high between edges k+2 and k+3, with the range visible on `core_id*` in that same cycle.
- `core_valid` is ignored in the cycle in which `core_wr_en` is high. It is sampled from the following cycle onward.
- Completion latency: `core_valid` high at edge m → `range_cnt`, `final_sum` and `done` update at edge m. The next `core_wr_en` (non-last, FIFO non-empty) goes high at edge m+2.
- Minimum issue period is 4 cycles per range, plus core time.
- The watchdog counts WAIT cycles only. `err` rises WDOG cycles after the `core_wr_en` cycle.
- `in_ready` falls in the cycle after the accepting edge of a `last` range and stays 0.

## Test plan
- **Reset values:** reset low for 2 cycles, then release → all outputs 0 except `in_ready`=1. Assert reset mid-WAIT → same values immediately (asynchronous).
- **Single range:** push 11–22 with last=1; core model returns sum 33 → `core_wr_en` exactly one cycle with id1=11, id2=22; `done`=1, `final_sum`=33, `range_cnt`=1; `in_ready`=0.
- **Swap and ordering:** push 115–95, then 1188511880–1188511890 (last); model sums 99 then 1188511885 → core sees id1=95, id2=115 first; `final_sum`=1188511984; `range_cnt`=2.
- **Backpressure:** hold core model busy and push 6 ranges with DEPTH=4 → `in_ready` drops after 4 accepted and rises when ISSUE pops. No entry is lost or duplicated, and issue order is FIFO.
- **Stale valid:** model holds `valid`=1 through the next `wr_en` cycle, then drops it for 5 cycles → the scheduler does not complete early; `range_cnt` increments only on the later assertion.
- **Watchdog:** WDOG=16, model never asserts `valid` → `err`=1 exactly 16 cycles after the `wr_en` cycle. No further pulses; `soft_clr` returns the scheduler to the reset state.

Source files
------------

// File: rtl/puzzle2_range_sched.sv
// puzzle2_range_sched
//   Buffers inclusive ID ranges from the input loader in a small FIFO and
//   hands them to the puzzle2_1 summing core one at a time. Each range is
//   started with a one-cycle core_wr_en pulse; the scheduler then waits for
//   core_valid. When the range marked last completes, the core's cumulative
//   sum is latched into final_sum and done is raised.
//
// Ports
//   clk, reset (async, active-low), soft_clr (sync clear, same effect)
//   in_valid/in_ready/in_lo/in_hi/in_last : loader stream
//   core_wr_en/core_id1/core_id2           : range start to the core
//   core_valid/core_sum                    : core completion and running sum
//   busy, done, final_sum, range_cnt, err  : status

module puzzle2_range_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64,
    parameter int unsigned WDOG  = 1048576
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         soft_clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_lo,
    input  logic [W-1:0] in_hi,
    input  logic         in_last,
    output logic         core_wr_en,
    output logic [W-1:0] core_id1,
    output logic [W-1:0] core_id2,
    input  logic         core_valid,
    input  logic [W-1:0] core_sum,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] final_sum,
    output logic [15:0]  range_cnt,
    output logic         err
);

    localparam int unsigned     AW        = $clog2(DEPTH);
    localparam int unsigned     WW        = $clog2(WDOG);
    localparam logic [AW:0]     C_FULL    = (AW+1)'(DEPTH);
    localparam logic [WW-1:0]   C_WD_LAST = WW'(WDOG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [W-1:0]    r_mem_lo   [DEPTH];
    logic [W-1:0]    r_mem_hi   [DEPTH];
    logic            r_mem_last [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            r_last_seen;
    logic            r_inflight_last;
    logic            r_blank;
    logic [WW-1:0]   r_wd;
    logic            r_wr_en;
    logic [W-1:0]    r_id1;
    logic [W-1:0]    r_id2;
    logic [W-1:0]    r_final;
    logic [15:0]     r_cnt;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_swap;
    logic            w_complete;
    logic            w_wd_exp;

    assign w_full     = (r_count == C_FULL);
    assign w_empty    = (r_count == '0);
    assign in_ready   = !w_full && !r_last_seen && (r_state != S_DONE) && (r_state != S_ERR);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == S_ISSUE);
    assign w_swap     = (in_lo > in_hi);
    // The first WAIT cycle is blanked so a valid level left over from the
    // previous range cannot complete the new one.
    assign w_complete = (r_state == S_WAIT) && !r_blank && core_valid;
    assign w_wd_exp   = (r_state == S_WAIT) && !w_complete && (r_wd == C_WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_complete) begin
                    w_next = r_inflight_last ? S_DONE : S_IDLE;
                end else if (w_wd_exp) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_DONE;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
        if (soft_clr) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_lo[i]   <= '0;
                r_mem_hi[i]   <= '0;
                r_mem_last[i] <= 1'b0;
            end
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_last_seen     <= 1'b0;
            r_inflight_last <= 1'b0;
            r_blank         <= 1'b0;
            r_wd            <= '0;
            r_wr_en         <= 1'b0;
            r_id1           <= '0;
            r_id2           <= '0;
            r_final         <= '0;
            r_cnt           <= '0;
        end else if (soft_clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_lo[i]   <= '0;
                r_mem_hi[i]   <= '0;
                r_mem_last[i] <= 1'b0;
            end
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_last_seen     <= 1'b0;
            r_inflight_last <= 1'b0;
            r_blank         <= 1'b0;
            r_wd            <= '0;
            r_wr_en         <= 1'b0;
            r_id1           <= '0;
            r_id2           <= '0;
            r_final         <= '0;
            r_cnt           <= '0;
        end else begin
            r_wr_en <= w_pop;

            if (w_push) begin
                r_mem_lo[r_wptr]   <= w_swap ? in_hi : in_lo;
                r_mem_hi[r_wptr]   <= w_swap ? in_lo : in_hi;
                r_mem_last[r_wptr] <= in_last;
                r_wptr             <= r_wptr + 1'b1;
                if (in_last) r_last_seen <= 1'b1;
            end

            if (w_pop) begin
                r_id1           <= r_mem_lo[r_rptr];
                r_id2           <= r_mem_hi[r_rptr];
                r_inflight_last <= r_mem_last[r_rptr];
                r_rptr          <= r_rptr + 1'b1;
                r_wd            <= '0;
                r_blank         <= 1'b1;
            end else if (r_state == S_WAIT) begin
                r_blank <= 1'b0;
                r_wd    <= r_wd + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_complete) begin
                r_cnt <= r_cnt + 16'd1;
                if (r_inflight_last) r_final <= core_sum;
            end
        end
    end

    assign core_wr_en = r_wr_en;
    assign core_id1   = r_id1;
    assign core_id2   = r_id2;
    assign busy       = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign final_sum  = r_final;
    assign range_cnt  = r_cnt;

endmodule
